// File: rtl/tl_scratchpad_responder.sv
// rtl/tl_scratchpad_responder.sv - TileLink-UH-subset scratchpad responder backed by a 64-bit RAM
module tl_scratchpad_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
    parameter int          DEPTH_WORDS = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in_a_valid,
    output logic        auto_in_a_ready,
    input  logic [2:0]  auto_in_a_bits_opcode,
    input  logic [2:0]  auto_in_a_bits_param,
    input  logic [3:0]  auto_in_a_bits_size,
    input  logic [1:0]  auto_in_a_bits_source,
    input  logic [31:0] auto_in_a_bits_address,
    input  logic [7:0]  auto_in_a_bits_mask,
    input  logic [63:0] auto_in_a_bits_data,
    input  logic        auto_in_a_bits_corrupt,
    output logic        auto_in_d_valid,
    input  logic        auto_in_d_ready,
    output logic [2:0]  auto_in_d_bits_opcode,
    output logic [1:0]  auto_in_d_bits_param,
    output logic [3:0]  auto_in_d_bits_size,
    output logic [1:0]  auto_in_d_bits_source,
    output logic [2:0]  auto_in_d_bits_sink,
    output logic        auto_in_d_bits_denied,
    output logic [63:0] auto_in_d_bits_data,
    output logic        auto_in_d_bits_corrupt
);
    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] REGION_BYTES = 33'(DEPTH_WORDS) * 33'd8;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_ACK} state_t;

    state_t            state;
    logic              a_ready_q;
    logic              d_valid_q;
    logic [11:0]       remain;
    logic [IDX_W-1:0]  idx;
    logic              lat_denied;
    logic [2:0]        d_opcode;
    logic [3:0]        d_size;
    logic [1:0]        d_source;
    logic              d_denied;
    logic              d_corrupt;

    logic [63:0]       mem [DEPTH_WORDS];
    logic [63:0]       ram_q;

    logic              a_fire;
    logic              d_fire;
    logic              is_get;
    logic              is_put;
    logic [32:0]       addr_off;
    logic              in_range;
    logic [6:0]        align_mask;
    logic              aligned;
    logic              a_denied;
    logic [12:0]       a_beats;
    logic [11:0]       a_beats_m1;
    logic [IDX_W-1:0]  a_idx;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_widx;
    logic              ram_re;
    logic [IDX_W-1:0]  ram_ridx;
    logic              unused_inputs;

    assign a_fire = auto_in_a_valid && a_ready_q;
    assign d_fire = d_valid_q && auto_in_d_ready;

    // Decode the A header presented in IDLE: legality, beat count and word index
    always_comb begin
        is_get     = (auto_in_a_bits_opcode == 3'd4);
        is_put     = (auto_in_a_bits_opcode == 3'd0) || (auto_in_a_bits_opcode == 3'd1);
        addr_off   = {1'b0, auto_in_a_bits_address} - {1'b0, BASE_ADDR};
        in_range   = (auto_in_a_bits_address >= BASE_ADDR) && (addr_off < REGION_BYTES);
        align_mask = (7'd1 << auto_in_a_bits_size[2:0]) - 7'd1;
        aligned    = ((auto_in_a_bits_address[6:0] & align_mask) == 7'd0);
        a_denied   = !(is_get || is_put) || (auto_in_a_bits_size > 4'd6) || !in_range || !aligned;
        a_beats    = (auto_in_a_bits_size <= 4'd3) ? 13'd1
                                                   : (13'd1 << (auto_in_a_bits_size - 4'd3));
        a_beats_m1 = 12'(a_beats - 13'd1);
        a_idx      = addr_off[IDX_W+2:3];
    end

    // Oversized denied Puts may present beat counts beyond 12 bits only in the discarded MSB
    assign unused_inputs = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt, addr_off, a_beats[12]};

    // RAM port control: writes on accepted Put beats, reads on Get accept and each non-final D fire
    always_comb begin
        ram_we   = a_fire && (((state == S_IDLE) && is_put && !a_denied) ||
                              ((state == S_WRITE) && !lat_denied));
        ram_widx = (state == S_IDLE) ? a_idx : idx;
        ram_re   = ((state == S_IDLE) && a_fire && !is_put) ||
                   ((state == S_READ) && d_fire && (remain != 12'd0));
        ram_ridx = (state == S_IDLE) ? a_idx : idx + IDX_W'(1);
    end

    // Byte-enabled RAM write and synchronous read; contents are never reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem[ram_widx][b*8 +: 8] <= auto_in_a_bits_data[b*8 +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_q <= mem[ram_ridx];
        end
    end

    // Transaction FSM with registered handshake and D-channel fields
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            a_ready_q  <= 1'b0;
            d_valid_q  <= 1'b0;
            remain     <= '0;
            idx        <= '0;
            lat_denied <= 1'b0;
            d_opcode   <= '0;
            d_size     <= '0;
            d_source   <= '0;
            d_denied   <= 1'b0;
            d_corrupt  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_fire) begin
                        d_size     <= auto_in_a_bits_size;
                        d_source   <= auto_in_a_bits_source;
                        d_denied   <= a_denied;
                        lat_denied <= a_denied;
                        remain     <= a_beats_m1;
                        if (is_put) begin
                            idx <= a_idx + IDX_W'(1);
                            if (a_beats_m1 == 12'd0) begin
                                state     <= S_ACK;
                                a_ready_q <= 1'b0;
                                d_valid_q <= 1'b1;
                                d_opcode  <= 3'd0;
                                d_corrupt <= 1'b0;
                            end else begin
                                state <= S_WRITE;
                            end
                        end else begin
                            idx       <= a_idx;
                            state     <= S_READ;
                            a_ready_q <= 1'b0;
                            d_valid_q <= 1'b1;
                            d_opcode  <= 3'd1;
                            d_corrupt <= a_denied;
                        end
                    end
                end
                S_READ: begin
                    if (d_fire) begin
                        if (remain == 12'd0) begin
                            state     <= S_IDLE;
                            d_valid_q <= 1'b0;
                            a_ready_q <= 1'b1;
                        end else begin
                            remain <= remain - 12'd1;
                            idx    <= idx + IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (a_fire) begin
                        remain <= remain - 12'd1;
                        idx    <= idx + IDX_W'(1);
                        if (remain == 12'd1) begin
                            state     <= S_ACK;
                            a_ready_q <= 1'b0;
                            d_valid_q <= 1'b1;
                            d_opcode  <= 3'd0;
                            d_corrupt <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (d_fire) begin
                        state     <= S_IDLE;
                        d_valid_q <= 1'b0;
                        a_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign auto_in_a_ready        = a_ready_q;
    assign auto_in_d_valid        = d_valid_q;
    assign auto_in_d_bits_opcode  = d_opcode;
    assign auto_in_d_bits_param   = 2'd0;
    assign auto_in_d_bits_size    = d_size;
    assign auto_in_d_bits_source  = d_source;
    assign auto_in_d_bits_sink    = 3'd0;
    assign auto_in_d_bits_denied  = d_denied;
    assign auto_in_d_bits_corrupt = d_corrupt;
    assign auto_in_d_bits_data    = ((state == S_READ) && !d_denied) ? ram_q : 64'd0;

endmodule

// File: tb/tb_tl_scratchpad_responder.sv
// tb/tb_tl_scratchpad_responder.sv - directed self-checking bench for tl_scratchpad_responder
module tb_tl_scratchpad_responder;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [3:0]  a_size = '0;
    logic [1:0]  a_source = '0;
    logic [31:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        a_corrupt = 1'b0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [1:0]  d_source;
    logic [2:0]  d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic        d_corrupt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    tl_scratchpad_responder dut (
        .clock                  (clock),
        .reset                  (reset),
        .auto_in_a_valid        (a_valid),
        .auto_in_a_ready        (a_ready),
        .auto_in_a_bits_opcode  (a_opcode),
        .auto_in_a_bits_param   (a_param),
        .auto_in_a_bits_size    (a_size),
        .auto_in_a_bits_source  (a_source),
        .auto_in_a_bits_address (a_address),
        .auto_in_a_bits_mask    (a_mask),
        .auto_in_a_bits_data    (a_data),
        .auto_in_a_bits_corrupt (a_corrupt),
        .auto_in_d_valid        (d_valid),
        .auto_in_d_ready        (d_ready),
        .auto_in_d_bits_opcode  (d_opcode),
        .auto_in_d_bits_param   (d_param),
        .auto_in_d_bits_size    (d_size),
        .auto_in_d_bits_source  (d_source),
        .auto_in_d_bits_sink    (d_sink),
        .auto_in_d_bits_denied  (d_denied),
        .auto_in_d_bits_data    (d_data),
        .auto_in_d_bits_corrupt (d_corrupt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h0101_0101_0101_0101);
    endfunction

    // Present one A beat from a negedge, wait for a_ready, return at the negedge after the fire
    task automatic a_beat(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                          input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask,
                          input string tag);
        int n = 0;
        a_valid = 1'b1; a_opcode = op; a_size = size; a_source = src;
        a_address = addr; a_data = data; a_mask = mask;
        while (!a_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, " a_ready"}, 64'(a_ready), 64'd1);
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    // Wait for one D beat, optionally stall a cycle, check all fields, then accept it
    task automatic recv_d(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                          input logic den, input logic cor, input logic [63:0] data,
                          input bit stall, input string tag);
        int n = 0;
        while (!d_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, " d_valid"}, 64'(d_valid), 64'd1);
        if (stall) begin
            d_ready = 1'b0;
            @(negedge clock);
            check({tag, " held"}, 64'(d_valid), 64'd1);
        end
        check({tag, " hdr"}, 64'({d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt}),
              64'({op, 2'd0, size, src, 3'd0, den, cor}));
        check({tag, " data"}, d_data, data);
        d_ready = 1'b1;
        @(negedge clock);
        d_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst a_ready", 64'(a_ready), 64'd0);
        check("rst d_valid", 64'(d_valid), 64'd0);
        reset = 1'b1;
        #1 check("rel a_ready pre-edge", 64'(a_ready), 64'd0);
        @(negedge clock);
        check("rel a_ready", 64'(a_ready), 64'd1);

        // Full write then readback with source echo and latency 1
        a_beat(3'd0, 4'd3, 2'd2, BASE + 32'h10, 64'h1122_3344_5566_7788, 8'hFF, "putfull");
        recv_d(3'd0, 4'd3, 2'd2, 1'b0, 1'b0, 64'd0, 1'b0, "putfull ack");
        a_beat(3'd4, 4'd3, 2'd1, BASE + 32'h10, 64'd0, 8'hFF, "get1");
        check("get1 latency", 64'(d_valid), 64'd1);
        recv_d(3'd1, 4'd3, 2'd1, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 1'b0, "get1 aad");

        // Partial write over the low half
        a_beat(3'd1, 4'd3, 2'd0, BASE + 32'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, "putpart");
        recv_d(3'd0, 4'd3, 2'd0, 1'b0, 1'b0, 64'd0, 1'b0, "putpart ack");
        a_beat(3'd4, 4'd3, 2'd3, BASE + 32'h10, 64'd0, 8'hFF, "get2");
        recv_d(3'd1, 4'd3, 2'd3, 1'b0, 1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0, "get2 aad");

        // 8-beat burst write, then burst read with back-pressure on alternate beats
        for (int i = 0; i < 8; i++) a_beat(3'd0, 4'd6, 2'd3, BASE + 32'h40, pat(i), 8'hFF, "burst put");
        recv_d(3'd0, 4'd6, 2'd3, 1'b0, 1'b0, 64'd0, 1'b0, "burst ack");
        a_beat(3'd4, 4'd6, 2'd1, BASE + 32'h40, 64'd0, 8'hFF, "burst get");
        for (int i = 0; i < 8; i++) recv_d(3'd1, 4'd6, 2'd1, 1'b0, 1'b0, pat(i), (i % 2) == 0, "burst beat");
        check("burst end d_valid", 64'(d_valid), 64'd0);
        check("burst end a_ready", 64'(a_ready), 64'd1);

        // Denied reads: one past the region end, and misaligned size 4 (two beats)
        a_beat(3'd4, 4'd3, 2'd2, BASE + 32'h1000, 64'd0, 8'hFF, "oob get");
        recv_d(3'd1, 4'd3, 2'd2, 1'b1, 1'b1, 64'd0, 1'b0, "oob aad");
        check("oob single beat", 64'(d_valid), 64'd0);
        a_beat(3'd4, 4'd4, 2'd0, BASE + 32'h8, 64'd0, 8'hFF, "misal get");
        recv_d(3'd1, 4'd4, 2'd0, 1'b1, 1'b1, 64'd0, 1'b0, "misal beat0");
        recv_d(3'd1, 4'd4, 2'd0, 1'b1, 1'b1, 64'd0, 1'b0, "misal beat1");
        check("misal end d_valid", 64'(d_valid), 64'd0);

        // Denied writes: out-of-range PutFull and Arithmetic opcode must not touch RAM
        a_beat(3'd0, 4'd3, 2'd1, BASE + 32'h1000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, "oob put");
        recv_d(3'd0, 4'd3, 2'd1, 1'b1, 1'b0, 64'd0, 1'b0, "oob put ack");
        a_beat(3'd2, 4'd3, 2'd2, BASE + 32'h10, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, "arith");
        recv_d(3'd1, 4'd3, 2'd2, 1'b1, 1'b1, 64'd0, 1'b0, "arith aad");
        a_beat(3'd4, 4'd3, 2'd0, BASE + 32'h10, 64'd0, 8'hFF, "get3");
        recv_d(3'd1, 4'd3, 2'd0, 1'b0, 1'b0, 64'h1122_3344_BBBB_BBBB, 1'b0, "get3 unchanged");

        // Reset during beat 3 of an 8-beat read
        a_beat(3'd4, 4'd6, 2'd2, BASE + 32'h40, 64'd0, 8'hFF, "rst get");
        for (int i = 0; i < 3; i++) recv_d(3'd1, 4'd6, 2'd2, 1'b0, 1'b0, pat(i), 1'b0, "rst beat");
        check("rst beat3 data", d_data, pat(3));
        reset = 1'b0;
        #1;
        check("mid rst d_valid", 64'(d_valid), 64'd0);
        check("mid rst a_ready", 64'(a_ready), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post rst a_ready", 64'(a_ready), 64'd1);
        a_beat(3'd4, 4'd3, 2'd1, BASE + 32'h40, 64'd0, 8'hFF, "post rst get");
        recv_d(3'd1, 4'd3, 2'd1, 1'b0, 1'b0, pat(0), 1'b0, "post rst aad");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
